id_ex_pipe_stage: RTL and testbench
===================================

Name: id_ex_pipe_stage

Overview:
- Parametrised ID→EX pipeline stage. It is the successor to the fixed-width per-field ID/EX register bank.
- Carries one instruction bundle per beat: immediate, operand data, register addresses and a packed control word.
- Uses a valid/ready handshake with a 2-entry skid buffer. Stalls therefore back-propagate without combinational ready paths.
- Adds flush (bubble insertion) and x0 write-suppression.
- Sits between decode and execute. Upstream is the decoder/regfile read. Downstream is the ALU/forwarding unit.

Parameters:
- DATA_WIDTH, 32, width of imm and rs1/rs2 data.
- REGADDR_WIDTH, 5, width of rs1/rs2/rd addresses.
- CTRL_WIDTH, 16, width of packed control word (alu_op, load_type, op_b_sel, ram_read, ram_write, regs_write, ...).
- REGWR_BIT, 0, index of regs_write inside the control word.
- CNT_WIDTH, 16, width of perf counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held and incoming beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept; registered
- imm_in  input  DATA_WIDTH  selected immediate/offset
- rs1_data_in, rs2_data_in  input  DATA_WIDTH  operand data
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  REGADDR_WIDTH  register addresses
- ctrl_in  input  CTRL_WIDTH  control word
- out_valid  output  1  beat presented to EX
- out_ready  input  1  EX accepts
- imm_out, rs1_data_out, rs2_data_out  output  DATA_WIDTH  registered payload
- rs1_addr_out, rs2_addr_out, rd_addr_out  output  REGADDR_WIDTH  registered payload
- ctrl_out  output  CTRL_WIDTH  registered control; zero when out_valid=0
- stall_cnt, bubble_cnt  output  CNT_WIDTH  perf counters (feature only)

Behaviour:
- Reset (rst=0, asynchronous):
  - All payload and control registers clear to 0.
  - out_valid=0 and skid entry is empty.
  - in_ready=1 once rst deasserts; no beat is accepted while rst=0.
- Accept and consume:
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
- Storage: main register (drives outputs) plus skid register. State derives from the two valid bits.
  - EMPTY. On accept: load main → FULL.
  - FULL with accept and consume: main reloads → FULL.
  - FULL with accept and no consume: beat goes to skid → SKID. in_ready=0 next cycle.
  - FULL with consume and no accept: → EMPTY.
  - SKID: no accept, since in_ready=0. On consume, skid moves into main → FULL, and in_ready=1 next cycle.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Strict FIFO order; no beat is lost or duplicated.
- in_ready is a flop equal to "skid empty". It has no combinational path from out_ready.
- Bubble: whenever out_valid=0, ctrl_out=0 (no memory access, no regfile write). Data/address outputs hold their last value.
- x0 suppression: when a beat is captured with rd_addr_in==0, ctrl bit REGWR_BIT is stored as 0. All other ctrl bits pass unchanged.
- Flush, at the next edge:
  - Both valid bits clear and ctrl_out reads 0.
  - An accept in the same cycle is discarded.
  - Flush overrides accept and consume. A consume in the flush cycle still counts as delivered to EX.
  - in_ready=1 the following cycle.
- Simultaneous flush and reset: reset wins, because it is asynchronous.
- Reset asserted mid-transfer: state is lost and outputs clear immediately.

Optional Feature:
- Macro ID_EX_PIPE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - bubble_cnt increments each cycle with !out_valid && !flush.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both counters are tied to 0 and no counter flops are built. The port list is unchanged.

Test Plan:
- Reset, then stream 4 beats with imm 0x11..0x44, out_ready=1 → out_valid one cycle after each accept; imm_out = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; in_ready stays 1.
- Beat A accepted, out_ready=0, beat B offered → B goes to skid, in_ready=0 next cycle. Raise out_ready → A then B delivered in order; in_ready returns to 1.
- Beat with rd_addr_in=0, ctrl_in=0xFFFF, REGWR_BIT=0 → ctrl_out=0xFFFE. Same beat with rd=5 → ctrl_out=0xFFFF.
- SKID state, then pulse flush together with in_valid=1 → next cycle out_valid=0, ctrl_out=0, in_ready=1; the flushed beats never appear.
- Assert rst mid-stream, asynchronously off-edge → out_valid and all outputs are 0 before the next clk edge; first accepted beat after release appears normally.
- With ID_EX_PIPE_PERF_EN: hold out_ready=0 for 5 cycles with a valid beat → stall_cnt=5. Then 3 idle cycles → bubble_cnt=3.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_stage
// Purpose  : ID->EX pipeline register with valid/ready handshake, 2-entry skid
//            buffer, flush and x0 write-suppression. Optional perf counters are
//            built when ID_EX_PIPE_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module id_ex_pipe_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int CTRL_WIDTH    = 16,
    parameter int REGWR_BIT     = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    imm_in,
    input  logic [DATA_WIDTH-1:0]    rs1_data_in,
    input  logic [DATA_WIDTH-1:0]    rs2_data_in,
    input  logic [REGADDR_WIDTH-1:0] rs1_addr_in,
    input  logic [REGADDR_WIDTH-1:0] rs2_addr_in,
    input  logic [REGADDR_WIDTH-1:0] rd_addr_in,
    input  logic [CTRL_WIDTH-1:0]    ctrl_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    imm_out,
    output logic [DATA_WIDTH-1:0]    rs1_data_out,
    output logic [DATA_WIDTH-1:0]    rs2_data_out,
    output logic [REGADDR_WIDTH-1:0] rs1_addr_out,
    output logic [REGADDR_WIDTH-1:0] rs2_addr_out,
    output logic [REGADDR_WIDTH-1:0] rd_addr_out,
    output logic [CTRL_WIDTH-1:0]    ctrl_out,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    localparam int c_BUNDLE_W = 3*DATA_WIDTH + 3*REGADDR_WIDTH + CTRL_WIDTH;

    logic [c_BUNDLE_W-1:0] r_main;
    logic [c_BUNDLE_W-1:0] r_skid;
    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic                  r_in_ready;

    logic [CTRL_WIDTH-1:0] w_ctrl_in;
    logic [CTRL_WIDTH-1:0] w_main_ctrl;
    logic [c_BUNDLE_W-1:0] w_bundle;
    logic                  w_accept;
    logic                  w_consume;

    // A write to x0 is architecturally a no-op, so drop regs_write at capture.
    always_comb begin
        w_ctrl_in = ctrl_in;
        if (rd_addr_in == '0) begin
            w_ctrl_in[REGWR_BIT] = 1'b0;
        end
    end

    assign w_bundle  = {imm_in, rs1_data_in, rs2_data_in,
                        rs1_addr_in, rs2_addr_in, rd_addr_in, w_ctrl_in};
    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_main_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            // in_ready is low here, so only draining is possible.
            if (w_consume) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (r_main_valid) begin
            if (w_accept && !w_consume) begin
                r_skid       <= w_bundle;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end else if (w_accept) begin
                r_main <= w_bundle;
            end else if (w_consume) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_main       <= w_bundle;
            r_main_valid <= 1'b1;
        end
    end

    assign {imm_out, rs1_data_out, rs2_data_out,
            rs1_addr_out, rs2_addr_out, rd_addr_out, w_main_ctrl} = r_main;

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign ctrl_out  = r_main_valid ? w_main_ctrl : '0;

`ifdef ID_EX_PIPE_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_main_valid && !flush && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_stage
// Purpose  : Self-checking bench for id_ex_pipe_stage against a queue model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_pipe_stage;

    localparam int c_DW  = 32;
    localparam int c_AW  = 5;
    localparam int c_CW  = 16;
    localparam int c_RWB = 0;
    localparam int c_NW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [c_DW-1:0] imm_in = '0, rs1_data_in = '0, rs2_data_in = '0;
    logic [c_AW-1:0] rs1_addr_in = '0, rs2_addr_in = '0, rd_addr_in = '0;
    logic [c_CW-1:0] ctrl_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [c_DW-1:0] imm_out, rs1_data_out, rs2_data_out;
    logic [c_AW-1:0] rs1_addr_out, rs2_addr_out, rd_addr_out;
    logic [c_CW-1:0] ctrl_out;
    logic [c_NW-1:0] stall_cnt, bubble_cnt;

    id_ex_pipe_stage #(
        .DATA_WIDTH(c_DW), .REGADDR_WIDTH(c_AW), .CTRL_WIDTH(c_CW),
        .REGWR_BIT(c_RWB), .CNT_WIDTH(c_NW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
        .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out),
        .ctrl_out(ctrl_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_DW-1:0] imm, rs1d, rs2d;
        logic [c_AW-1:0] rs1a, rs2a, rda;
        logic [c_CW-1:0] ctrl;
    } beat_t;

    beat_t mq[$];     // beats accepted but not yet delivered, oldest first
    int    stall_m  = 0;
    int    bubble_m = 0;
    int    checks   = 0;
    int    errors   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.imm  = imm_in;      b.rs1d = rs1_data_in; b.rs2d = rs2_data_in;
        b.rs1a = rs1_addr_in; b.rs2a = rs2_addr_in; b.rda  = rd_addr_in;
        b.ctrl = ctrl_in;
        if (rd_addr_in == 0) b.ctrl[c_RWB] = 1'b0;
        return b;
    endfunction

    task automatic compare();
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            check("imm_out", 64'(imm_out), 64'(mq[0].imm));
            check("rs1_data_out", 64'(rs1_data_out), 64'(mq[0].rs1d));
            check("rs2_data_out", 64'(rs2_data_out), 64'(mq[0].rs2d));
            check("rs1_addr_out", 64'(rs1_addr_out), 64'(mq[0].rs1a));
            check("rs2_addr_out", 64'(rs2_addr_out), 64'(mq[0].rs2a));
            check("rd_addr_out", 64'(rd_addr_out), 64'(mq[0].rda));
            check("ctrl_out", 64'(ctrl_out), 64'(mq[0].ctrl));
        end else begin
            check("ctrl_out_bubble", 64'(ctrl_out), 64'd0);
        end
`ifdef ID_EX_PIPE_PERF_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        check("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`else
        check("stall_cnt_off", 64'(stall_cnt), 64'd0);
        check("bubble_cnt_off", 64'(bubble_cnt), 64'd0);
`endif
    endtask

    // One clock: decide the handshake from the pre-edge view, then update the model.
    task automatic cycle();
        bit    acc, cons, stl, bub;
        beat_t b;
        acc  = in_valid && (mq.size() < 2);
        cons = (mq.size() > 0) && out_ready;
        stl  = (mq.size() > 0) && !out_ready;
        bub  = (mq.size() == 0) && !flush;
        b    = cur_beat();
        @(posedge clk);
        if (rst) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (cons) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
            if (stl && stall_m < 65535) stall_m++;
            if (bub && bubble_m < 65535) bubble_m++;
        end
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [c_DW-1:0] imm,
                         input logic [c_AW-1:0] rd, input logic [c_CW-1:0] ctrl);
        in_valid    = v;
        imm_in      = imm;
        rs1_data_in = $urandom;
        rs2_data_in = $urandom;
        rs1_addr_in = c_AW'($urandom);
        rs2_addr_in = c_AW'($urandom);
        rd_addr_in  = rd;
        ctrl_in     = ctrl;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
        check("rst_imm_out", 64'(imm_out), 64'd0);
        check("rst_rd_addr_out", 64'(rd_addr_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Stream 0x11..0x44 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, c_DW'(i * 'h11), 5'd3, 16'h00F1);
            cycle();
            check("stream_imm", 64'(imm_out), 64'(i * 'h11));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, 5'd1, '0);
        cycle();

        // Skid: A held, B offered
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd7, 16'h0003);
        cycle();
        drive(1'b1, 32'hB, 5'd8, 16'h0005);
        cycle();
        check("skid_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, '0, 5'd1, '0);
        repeat (4) cycle();             // stall cycles
        out_ready = 1'b1;
        cycle();
        check("skid_first", 64'(imm_out), 64'hB);
        check("skid_ready_back", 64'(in_ready), 64'd1);
        cycle();
        repeat (3) cycle();             // idle cycles

        // x0 suppression
        drive(1'b1, 32'h55, 5'd0, 16'hFFFF);
        cycle();
        check("x0_ctrl", 64'(ctrl_out), 64'hFFFE);
        drive(1'b1, 32'h55, 5'd5, 16'hFFFF);
        cycle();
        check("x5_ctrl", 64'(ctrl_out), 64'hFFFF);

        // Flush in SKID state with a beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'hC, 5'd2, 16'h0007);
        cycle();
        drive(1'b1, 32'hD, 5'd2, 16'h0007);
        cycle();
        flush = 1'b1;
        drive(1'b1, 32'hE, 5'd2, 16'h0007);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, 5'd1, '0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(ctrl_out), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h77, 5'd4, 16'h00FF);
        cycle();
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        stall_m  = 0;
        bubble_m = 0;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl", 64'(ctrl_out), 64'd0);
        check("arst_imm", 64'(imm_out), 64'd0);
        check("arst_rs1_data", 64'(rs1_data_out), 64'd0);
        check("arst_rs2_addr", 64'(rs2_addr_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h88, 5'd6, 16'h0011);
        cycle();
        check("post_rst_imm", 64'(imm_out), 64'h88);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, c_AW'($urandom_range(0, 3)), c_CW'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
